// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared types and constants for the 5-stage pipeline hazard controller.
//   FWD_*      : ALU operand-mux select encodings
//   hz_entry_t : one scoreboard entry {valid, regwr, is_load, dst}
//   REG_ZERO   : register $0, which never creates a hazard
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM ALUout
    localparam logic [1:0] FWD_MEMWR = 2'b10;  // operand from MEM/WR result

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic       regwr;
        logic       is_load;
        logic [4:0] dst;
    } hz_entry_t;

    localparam int HZ_ENTRY_W = $bits(hz_entry_t);

    localparam hz_entry_t HZ_EMPTY = '0;

    // An entry can only be a producer if it is a real instruction that
    // writes a register other than $0.
    function automatic logic entry_match(input hz_entry_t e);
        return e.valid & e.regwr & (e.dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/hz_src_match.sv
// -----------------------------------------------------------------------------
// hz_src_match
// Compares one source register of the ID instruction against the three
// in-flight scoreboard entries.
// Ports:
//   id_valid   in  ID stage holds a real instruction
//   src_used   in  the ID instruction actually reads this source
//   src        in  5-bit source register number
//   ex_entry   in  scoreboard entry of the instruction in EX
//   mem_entry  in  scoreboard entry of the instruction in MEM
//   wr_entry   in  scoreboard entry of the instruction in WR
//   hit_ex     out source depends on the EX instruction
//   hit_mem    out source depends on the MEM instruction
//   hit_wr     out source depends on the WR instruction
//   ex_is_load out the EX instruction is a load
// -----------------------------------------------------------------------------
module hz_src_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                  id_valid,
    input  logic                  src_used,
    input  logic [4:0]            src,
    input  logic [HZ_ENTRY_W-1:0] ex_entry,
    input  logic [HZ_ENTRY_W-1:0] mem_entry,
    input  logic [HZ_ENTRY_W-1:0] wr_entry,
    output logic                  hit_ex,
    output logic                  hit_mem,
    output logic                  hit_wr,
    output logic                  ex_is_load
);

    hz_entry_t ex_e, mem_e, wr_e;
    logic      reads;

    assign ex_e  = ex_entry;
    assign mem_e = mem_entry;
    assign wr_e  = wr_entry;

    assign reads = id_valid & src_used;

    assign hit_ex     = reads & (ex_e.dst  == src) & entry_match(ex_e);
    assign hit_mem    = reads & (mem_e.dst == src) & entry_match(mem_e);
    assign hit_wr     = reads & (wr_e.dst  == src) & entry_match(wr_e);
    assign ex_is_load = ex_e.is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for the IF/ID/EX/MEM/WR pipeline. Tracks destinations of
// the instructions in EX, MEM and WR, and produces PC / IF/ID / ID/EX
// stall-bubble-flush controls plus registered ALU forwarding selects.
// State advances on the falling edge of clk, together with the pipeline
// registers.
// Ports:
//   clk, rst_n         falling-edge clock, async active-low reset
//   id_*               decoded fields of the instruction currently in ID
//   ex_branch_taken    taken branch resolved in EX (flush request)
//   pc_en, ifid_en     PC / IF/ID load enables (low while stalling)
//   ifid_flush         load a bubble into IF/ID
//   idex_bubble        load a bubble into ID/EX
//   fwd_a, fwd_b       operand selects for the instruction now in EX
//   stall_cnt          saturating count of stall cycles
//   flush_cnt          saturating count of flush cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regwr,
    input  logic [4:0]       id_dst,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_entry_t ex_q, mem_q, wr_q;
    hz_entry_t id_entry;

    logic hit_ex_a, hit_mem_a, hit_wr_a, ex_load_a;
    logic hit_ex_b, hit_mem_b, hit_wr_b, ex_load_b;
    logic stall_cond, stall, flush;
    logic [1:0] fwd_a_d, fwd_b_d;

    // A WR-stage match is harmless: the register file writes before it reads.
    logic unused_wr_hits;
    assign unused_wr_hits = hit_wr_a | hit_wr_b;

    hz_src_match u_match_rs (
        .id_valid   (id_valid),
        .src_used   (id_uses_rs),
        .src        (id_rs),
        .ex_entry   (ex_q),
        .mem_entry  (mem_q),
        .wr_entry   (wr_q),
        .hit_ex     (hit_ex_a),
        .hit_mem    (hit_mem_a),
        .hit_wr     (hit_wr_a),
        .ex_is_load (ex_load_a)
    );

    hz_src_match u_match_rt (
        .id_valid   (id_valid),
        .src_used   (id_uses_rt),
        .src        (id_rt),
        .ex_entry   (ex_q),
        .mem_entry  (mem_q),
        .wr_entry   (wr_q),
        .hit_ex     (hit_ex_b),
        .hit_mem    (hit_mem_b),
        .hit_wr     (hit_wr_b),
        .ex_is_load (ex_load_b)
    );

    assign id_entry = '{valid: id_valid, regwr: id_regwr,
                        is_load: id_is_load, dst: id_dst};

    // With bypassing only a load in EX is too late; without it any producer
    // still in EX or MEM must drain to WR first.
    assign stall_cond = FORWARD_EN ? ((hit_ex_a & ex_load_a) | (hit_ex_b & ex_load_b))
                                   : (hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b);

    // A taken branch discards the ID instruction, so its hazard is moot.
    assign flush = ex_branch_taken;
    assign stall = stall_cond & ~flush;

    assign pc_en       = ~stall;
    assign ifid_en     = ~stall;
    assign ifid_flush  = flush;
    assign idex_bubble = stall | flush;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (FORWARD_EN && !stall && !flush) begin
            // EX holds the youngest producer, so it wins over MEM.
            if (hit_ex_a && !ex_load_a) fwd_a_d = FWD_EXMEM;
            else if (hit_mem_a)         fwd_a_d = FWD_MEMWR;
            if (hit_ex_b && !ex_load_b) fwd_b_d = FWD_EXMEM;
            else if (hit_mem_b)         fwd_b_d = FWD_MEMWR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, exactly like the pipeline registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= HZ_EMPTY;
            mem_q     <= HZ_EMPTY;
            wr_q      <= HZ_EMPTY;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wr_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (stall || flush) ? HZ_EMPTY : id_entry;
            fwd_a <= fwd_a_d;
            fwd_b <= fwd_b_d;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
